load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/rv_mem_pkg.sv | 76 +++++++
 rtl/load_extend.sv | 22 ++
 rtl/load_store_unit.sv | 159 +++++++++++++++
 tb/tb_load_store_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// Shared encodings for the RV32 load/store path: funct3 width codes,
// data_memory write/size encodings, the LSU state type and small decode helpers.
package rv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_BYTE = 2'b01;
    localparam logic [1:0] MW_HALF = 2'b10;
    localparam logic [1:0] MW_WORD = 2'b11;

    localparam logic [1:0] MS_BYTE = 2'b00;
    localparam logic [1:0] MS_HALF = 2'b01;
    localparam logic [1:0] MS_WORD = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'd0,
        LSU_SPLIT = 2'd1,
        LSU_DONE  = 2'd2
    } lsu_state_t;

    // Unsigned widths exist only for loads; both request kinds at once is never legal.
    function automatic logic f3_legal(input logic ld, input logic st, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (!(ld && st)) begin
            case (f3)
                F3_B, F3_H, F3_W: ok = 1'b1;
                F3_BU, F3_HU:     ok = ld;
                default:          ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    function automatic logic [1:0] f3_mem_size(input logic [2:0] f3);
        logic [1:0] sz;
        case (f3)
            F3_B, F3_BU: sz = MS_BYTE;
            F3_H, F3_HU: sz = MS_HALF;
            default:     sz = MS_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic [1:0] f3_mem_write(input logic [2:0] f3);
        logic [1:0] mw;
        case (f3)
            F3_B:    mw = MW_BYTE;
            F3_H:    mw = MW_HALF;
            F3_W:    mw = MW_WORD;
            default: mw = MW_NONE;
        endcase
        return mw;
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic mis;
        case (f3)
            F3_H, F3_HU: mis = a[0];
            F3_W:        mis = (a != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Index of the final byte beat of a split access (N-1).
    function automatic logic [1:0] f3_last_beat(input logic [2:0] f3);
        return (f3 == F3_H || f3 == F3_HU) ? 2'd1 : 2'd3;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of load data by funct3. Used for both the aligned
// path (memory data) and the reassembled split-load buffer.
module load_extend
    import rv_mem_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    // Extend the low byte/half; words pass through untouched.
    always_comb begin
        case (i_funct3)
            F3_B:    o_data = {{24{i_data[7]}}, i_data[7:0]};
            F3_H:    o_data = {{16{i_data[15]}}, i_data[15:0]};
            F3_BU:   o_data = {24'd0, i_data[7:0]};
            F3_HU:   o_data = {16'd0, i_data[15:0]};
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit. Aligned accesses go straight to data_memory in
// one cycle; misaligned halves/words are split into byte beats.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  LSU_IDLE  | accept requests; aligned ones complete in this cycle
//  LSU_SPLIT | one byte beat per cycle at latched addr + k, pipeline held
//  LSU_DONE  | split access complete; load result presented, back to IDLE
module load_store_unit
    import rv_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_write,
    output logic [1:0]  mem_size,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        stall,
    output logic        err
);

    lsu_state_t  r_state;
    logic [1:0]  r_k;
    logic [1:0]  r_last_k;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic        r_is_load;
    logic [31:0] r_buf;

    logic        w_active;
    logic        w_legal;
    logic        w_misaligned;
    logic        w_start_split;
    logic [7:0]  w_split_byte;
    logic [31:0] w_ext_in;
    logic [2:0]  w_ext_f3;
    logic [31:0] w_ext_out;

    assign w_active     = req_valid & (req_load | req_store);
    assign w_legal      = f3_legal(req_load, req_store, funct3);
    assign w_misaligned = f3_misaligned(funct3, addr[1:0]);
    assign w_split_byte = r_wdata[{r_k, 3'b000} +: 8];

    // The DONE cycle extends the reassembled buffer; otherwise the live memory data.
    assign w_ext_in = (r_state == LSU_DONE) ? r_buf : mem_rdata;
    assign w_ext_f3 = (r_state == LSU_DONE) ? r_funct3 : funct3;

    load_extend u_load_extend (
        .i_data   (w_ext_in),
        .i_funct3 (w_ext_f3),
        .o_data   (w_ext_out)
    );

    // Output decode; reset forces the quiet values immediately, without waiting for a clock.
    always_comb begin
        mem_address   = addr;
        mem_wdata     = wdata;
        mem_write     = MW_NONE;
        mem_size      = MS_WORD;
        rdata         = 32'd0;
        rdata_valid   = 1'b0;
        stall         = 1'b0;
        err           = 1'b0;
        w_start_split = 1'b0;
        if (!reset) begin
            case (r_state)
                LSU_IDLE: begin
                    if (w_active) begin
                        if (!w_legal) begin
                            err = 1'b1;
                        end else if (w_misaligned) begin
                            stall         = 1'b1;
                            w_start_split = 1'b1;
                        end else begin
                            mem_size = f3_mem_size(funct3);
                            if (req_store) begin
                                mem_write = f3_mem_write(funct3);
                            end else begin
                                rdata       = w_ext_out;
                                rdata_valid = 1'b1;
                            end
                        end
                    end
                end
                LSU_SPLIT: begin
                    mem_address = r_addr + {30'd0, r_k};
                    mem_size    = MS_BYTE;
                    stall       = 1'b1;
                    if (!r_is_load) begin
                        mem_write = MW_BYTE;
                        mem_wdata = {24'd0, w_split_byte};
                    end
                end
                LSU_DONE: begin
                    if (r_is_load) begin
                        rdata       = w_ext_out;
                        rdata_valid = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM, beat counter, latched request and split-load buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= LSU_IDLE;
            r_k       <= 2'd0;
            r_last_k  <= 2'd0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_funct3  <= 3'd0;
            r_is_load <= 1'b0;
            r_buf     <= 32'd0;
        end else begin
            case (r_state)
                LSU_IDLE: begin
                    if (w_start_split) begin
                        r_addr    <= addr;
                        r_wdata   <= wdata;
                        r_funct3  <= funct3;
                        r_is_load <= req_load;
                        r_k       <= 2'd0;
                        r_last_k  <= f3_last_beat(funct3);
                        r_buf     <= 32'd0;
                        r_state   <= LSU_SPLIT;
                    end
                end
                LSU_SPLIT: begin
                    if (r_is_load) begin
                        r_buf[{r_k, 3'b000} +: 8] <= mem_rdata[7:0];
                    end
                    r_k <= r_k + 2'd1;
                    if (r_k == r_last_k) begin
                        r_state <= LSU_DONE;
                    end
                end
                LSU_DONE: begin
                    r_state <= LSU_IDLE;
                end
                default: begin
                    r_state <= LSU_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a 1 KiB byte memory environment plus a
// transaction-level reference byte array, directed cases then random traffic.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_load, req_store;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, mem_rdata;
    logic [31:0] mem_address, mem_wdata, rdata;
    logic [1:0]  mem_write, mem_size;
    logic        rdata_valid, stall, err;

    logic [7:0]  mem     [0:1023];
    logic [7:0]  ref_mem [0:1023];
    logic        mem_clear;
    logic [9:0]  env_a;

    int errors = 0;
    int checks = 0;

    load_store_unit dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_load    (req_load),
        .req_store   (req_store),
        .funct3      (funct3),
        .addr        (addr),
        .wdata       (wdata),
        .mem_rdata   (mem_rdata),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_write   (mem_write),
        .mem_size    (mem_size),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .stall       (stall),
        .err         (err)
    );

    always #5 clk = ~clk;

    // data_memory: combinational read, byte/half sign-extended
    assign env_a = mem_address[9:0];
    always_comb begin
        case (mem_size)
            2'b00:   mem_rdata = {{24{mem[env_a][7]}}, mem[env_a]};
            2'b01:   mem_rdata = {{16{mem[env_a + 10'd1][7]}}, mem[env_a + 10'd1], mem[env_a]};
            default: mem_rdata = {mem[env_a + 10'd3], mem[env_a + 10'd2], mem[env_a + 10'd1], mem[env_a]};
        endcase
    end

    // data_memory: write at the rising edge
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
        end else begin
            case (mem_write)
                2'b01: mem[env_a] <= mem_wdata[7:0];
                2'b10: begin
                    mem[env_a]         <= mem_wdata[7:0];
                    mem[env_a + 10'd1] <= mem_wdata[15:8];
                end
                2'b11: begin
                    mem[env_a]         <= mem_wdata[7:0];
                    mem[env_a + 10'd1] <= mem_wdata[15:8];
                    mem[env_a + 10'd2] <= mem_wdata[23:16];
                    mem[env_a + 10'd3] <= mem_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_legal(input bit ld, input bit st, input int f3);
        if (ld && st) return 1'b0;
        if (f3 == 0 || f3 == 1 || f3 == 2) return 1'b1;
        if (f3 == 4 || f3 == 5) return ld;
        return 1'b0;
    endfunction

    function automatic int m_bytes(input int f3);
        if (f3 == 0 || f3 == 4) return 1;
        if (f3 == 1 || f3 == 5) return 2;
        return 4;
    endfunction

    // Reference: what a whole access should do, from the width rules and a byte array.
    task automatic model_access(input bit ld, input bit st, input int f3, input logic [31:0] a,
                                input logic [31:0] wd, output bit e_err, output bit e_valid,
                                output logic [31:0] e_rdata, output int e_stall);
        int nb;
        logic [31:0] v;
        e_err = 1'b0; e_valid = 1'b0; e_rdata = 32'd0; e_stall = 0;
        if (!m_legal(ld, st, f3)) begin
            e_err = 1'b1;
        end else begin
            nb = m_bytes(f3);
            e_stall = ((a % nb) != 0) ? nb + 1 : 0;
            if (st) begin
                for (int i = 0; i < nb; i++) ref_mem[(a + i) & 32'h3FF] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[(a + i) & 32'h3FF]) << (8*i));
                if (f3 == 0) v = {{24{v[7]}}, v[7:0]};
                if (f3 == 1) v = {{16{v[15]}}, v[15:0]};
                e_rdata = v;
                e_valid = 1'b1;
            end
        end
    endtask

    task automatic do_access(input bit ld, input bit st, input int f3, input logic [31:0] a,
                             input logic [31:0] wd);
        bit e_err, e_valid, done;
        logic [31:0] e_rdata;
        int e_stall, cyc;
        model_access(ld, st, f3, a, wd, e_err, e_valid, e_rdata, e_stall);
        req_valid = 1'b1; req_load = ld; req_store = st;
        funct3 = 3'(f3); addr = a; wdata = wd;
        cyc = 0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (stall) begin
                if (cyc == 0) chk("mw_first_stall", 32'(mem_write), 32'd0);
                cyc++;
                if (cyc > 10) begin
                    chk("stall_bound", 32'(cyc), 32'(e_stall));
                    done = 1'b1;
                end
                @(posedge clk); #1;
            end else begin
                chk("stall_cycles", 32'(cyc), 32'(e_stall));
                chk("err", 32'(err), 32'(e_err));
                chk("rdata_valid", 32'(rdata_valid), 32'(e_valid));
                if (e_valid) chk("rdata", rdata, e_rdata);
                if (e_err) chk("mw_illegal", 32'(mem_write), 32'd0);
                @(posedge clk); #1;
                done = 1'b1;
            end
        end
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    endtask

    task automatic idle_check();
        req_valid = 1'($urandom_range(0, 1));
        req_load = 1'b0; req_store = 1'b0;
        if (!req_valid) begin
            req_load = 1'($urandom_range(0, 1));
            req_store = 1'($urandom_range(0, 1));
        end
        funct3 = 3'($urandom_range(0, 7));
        addr = $urandom; wdata = $urandom;
        @(negedge clk);
        chk("idle_mem_write", 32'(mem_write), 32'd0);
        chk("idle_mem_size", 32'(mem_size), 32'd2);
        chk("idle_err", 32'(err), 32'd0);
        chk("idle_rvalid", 32'(rdata_valid), 32'd0);
        chk("idle_addr", mem_address, addr);
        chk("idle_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int diff, r, f3;
        logic [31:0] a;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        reset = 1'b1; mem_clear = 1'b1;
        req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0;
        funct3 = 3'b010; addr = 32'h10; wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_size", 32'(mem_size), 32'd2);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rvalid", 32'(rdata_valid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        req_valid = 1'b0; req_load = 1'b0;
        mem_clear = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;

        do_access(0, 1, 2, 32'h10, 32'hDEADBEEF);
        do_access(1, 0, 2, 32'h10, 32'h0);
        do_access(0, 1, 0, 32'h20, 32'h00000080);
        do_access(1, 0, 0, 32'h20, 32'h0);
        do_access(1, 0, 4, 32'h20, 32'h0);

        do_access(0, 1, 2, 32'h31, 32'h11223344);
        chk("sw31_b0", 32'(mem[10'h31]), 32'h44);
        chk("sw31_b3", 32'(mem[10'h34]), 32'h11);
        do_access(1, 0, 2, 32'h31, 32'h0);

        do_access(0, 1, 1, 32'h3FF, 32'h0000A5F0);
        chk("sh3ff_lo", 32'(mem[10'h3FF]), 32'hF0);
        chk("sh3ff_wrap", 32'(mem[10'h000]), 32'hA5);
        do_access(1, 0, 5, 32'h3FF, 32'h0);

        do_access(0, 1, 0, 32'h43, 32'h5A);
        do_access(0, 1, 0, 32'h44, 32'h5A);
        req_valid = 1'b1; req_store = 1'b1; req_load = 1'b0;
        funct3 = 3'b010; addr = 32'h41; wdata = 32'hCAFEF00D;
        repeat (3) begin @(posedge clk); #1; end
        chk("split_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_split_stall", 32'(stall), 32'd0);
        chk("rst_split_mw", 32'(mem_write), 32'd0);
        req_valid = 1'b0; req_store = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        ref_mem[10'h41] = 8'h0D; ref_mem[10'h42] = 8'hF0;
        chk("abort_b43", 32'(mem[10'h43]), 32'h5A);
        chk("abort_b44", 32'(mem[10'h44]), 32'h5A);
        do_access(1, 0, 2, 32'h40, 32'h0);

        do_access(1, 0, 3, 32'h50, 32'h0);
        do_access(0, 1, 4, 32'h50, 32'h12345678);
        do_access(1, 1, 2, 32'h54, 32'h87654321);
        idle_check();
        idle_check();

        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 4) == 0) f3 = $urandom_range(0, 7);
            else case ($urandom_range(0, 4))
                0: f3 = 0; 1: f3 = 1; 2: f3 = 2; 3: f3 = 4; default: f3 = 5;
            endcase
            case ($urandom_range(0, 19))
                0, 1:    a = $urandom;
                2, 3, 4: a = 32'h3F8 + $urandom_range(0, 7);
                default: a = 32'h100 + $urandom_range(0, 63);
            endcase
            if (r == 9) idle_check();
            else if (r == 0) do_access(1, 1, f3, a, $urandom);
            else if (r <= 4) do_access(1, 0, f3, a, $urandom);
            else do_access(0, 1, f3, a, $urandom);
        end

        diff = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) diff++;
        chk("mem_final_diff", 32'(diff), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
